// File: rtl/change_dispenser.sv
// Greedy three-denomination change payout with a req/ack coin handshake and ack timeout.
// Define CHANGE_TUBE_EN to add per-tube stock counters, refill inputs and tube_empty flags.
module change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int VAL0      = 25,
  parameter int VAL1      = 10,
  parameter int VAL2      = 5,
  parameter int TUBE_W    = 6,
  parameter int TUBE_INIT = 20,
  parameter int ACK_TO    = 255,
  parameter int TO_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  output logic [2:0]       coin_req,
  output logic             active,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] remainder
`ifdef CHANGE_TUBE_EN
  ,
  input  logic              refill,
  input  logic [1:0]        refill_sel,
  input  logic [TUBE_W-1:0] refill_cnt,
  output logic [2:0]        tube_empty
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQ, S_DONE} state_t;

  localparam logic [AMT_W-1:0] C_VAL [3] = '{AMT_W'(VAL0), AMT_W'(VAL1), AMT_W'(VAL2)};

  state_t           r_state, w_state_next;
  logic [AMT_W-1:0] r_bal, w_bal_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [TO_W-1:0]  r_to_cnt, w_to_next;
  logic             r_short, w_short_next;
  logic             r_fault, w_fault_next;
  logic [AMT_W-1:0] r_rem, w_rem_next;
  logic [2:0]       w_avail;
  logic [2:0]       w_elig;
  logic [1:0]       w_pick;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_elig
      assign w_elig[gi] = (r_bal >= C_VAL[gi]) && w_avail[gi];
    end
  endgenerate

  // Lowest index wins, which is the largest coin: greedy payout.
  assign w_pick = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);

`ifdef CHANGE_TUBE_EN
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tube
      logic [TUBE_W-1:0] r_tube;
      logic [TUBE_W:0]   w_sum;
      logic              w_add;
      logic              w_dec;

      assign w_add = refill && (refill_sel == 2'(gi));
      assign w_dec = (r_state == S_REQ) && coin_ack && (r_sel == 2'(gi));
      // A tube is only selected when nonempty, so the decrement cannot wrap.
      assign w_sum = {1'b0, r_tube} + (w_add ? {1'b0, refill_cnt} : '0)
                   - {{TUBE_W{1'b0}}, w_dec};

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_tube <= TUBE_W'(TUBE_INIT);
        else if (w_sum[TUBE_W])
          r_tube <= '1;
        else
          r_tube <= w_sum[TUBE_W-1:0];
      end

      assign w_avail[gi]    = (r_tube != '0);
      assign tube_empty[gi] = (r_tube == '0);
    end
  endgenerate
`else
  // Unlimited supply; the expression folds to constant ones.
  assign w_avail = {3{(TUBE_W > 0) || (TUBE_INIT >= 0)}};
`endif

  always_comb begin
    w_state_next = r_state;
    w_bal_next   = r_bal;
    w_sel_next   = r_sel;
    w_to_next    = r_to_cnt;
    w_short_next = r_short;
    w_fault_next = r_fault;
    w_rem_next   = r_rem;
    coin_req     = 3'b000;
    active       = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_bal_next   = amount;
          w_short_next = 1'b0;
          w_fault_next = 1'b0;
          w_rem_next   = '0;
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        active = 1'b1;
        if (|w_elig) begin
          w_sel_next   = w_pick;
          w_to_next    = '0;
          w_state_next = S_REQ;
        end else begin
          w_rem_next   = r_bal;
          w_short_next = (r_bal != '0);
          w_state_next = S_DONE;
        end
      end
      S_REQ: begin
        active   = 1'b1;
        coin_req = 3'b001 << r_sel;
        if (coin_ack) begin
          w_bal_next   = r_bal - C_VAL[r_sel];
          w_state_next = S_SELECT;
        end else if ((ACK_TO != 0) && (r_to_cnt == TO_W'(ACK_TO - 1))) begin
          w_fault_next = 1'b1;
          w_short_next = 1'b1;
          w_rem_next   = r_bal;
          w_state_next = S_DONE;
        end else begin
          w_to_next = r_to_cnt + TO_W'(1);
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bal    <= '0;
      r_sel    <= '0;
      r_to_cnt <= '0;
      r_short  <= 1'b0;
      r_fault  <= 1'b0;
      r_rem    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_bal    <= w_bal_next;
      r_sel    <= w_sel_next;
      r_to_cnt <= w_to_next;
      r_short  <= w_short_next;
      r_fault  <= w_fault_next;
      r_rem    <= w_rem_next;
    end
  end

  assign short     = r_short;
  assign fault     = r_fault;
  assign remainder = r_rem;

endmodule
